// File: rtl/prog_loader.sv
// prog_loader -- serial program loader.
//
// Assembles a stream of received bytes into 16-bit instruction words
// (high byte first) and writes each word to program memory at consecutive
// addresses starting from 0. Loading ends when an HLT word (opcode 5'b00000)
// has been written, after which the CPU is released. Running past the top of
// program memory aborts the session with an error instead of wrapping.
//
// Optional feature (macro PROG_LOADER_CKSUM_EN): after the HLT word one more
// byte is expected, which must equal the XOR of every data byte of the
// session; a mismatch ends the session in error.
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst       asynchronous active-high reset
//   i_start     one-cycle pulse, starts (or restarts) a load session
//   i_rx_valid  one-cycle strobe qualifying i_rx_data
//   i_rx_data   received byte
//   o_mem_we    program-memory write enable, one pulse per word
//   o_mem_addr  program-memory write address
//   o_mem_data  instruction word being written
//   o_count     number of words written in this session
//   o_done      session completed successfully (level)
//   o_cpu_en    CPU release, identical to o_done
//   o_err       session failed (level)

module prog_loader #(
  parameter int ADDR_W = 11,
  parameter int INST_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [INST_W-1:0] o_mem_data,
  output logic [ADDR_W:0]   o_count,
  output logic              o_done,
  output logic              o_cpu_en,
  output logic              o_err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_HI,
    LOAD_LO,
    WRITE,
    DONE,
    ERR
`ifdef PROG_LOADER_CKSUM_EN
    , CKSUM
`endif
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   count;
  logic [7:0]        hi_byte;
  logic              hold_valid;
  logic [7:0]        hold_data;

  logic              restart;
  logic              byte_avail;
  logic [7:0]        byte_val;
  logic              is_hlt;
  logic              addr_full;

`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0]        cksum;
`endif

  // A byte captured while the word was being written takes precedence over
  // the live receiver, so bytes are consumed strictly in arrival order.
  assign byte_avail = hold_valid | i_rx_valid;
  assign byte_val   = hold_valid ? hold_data : i_rx_data;

  // The write cycle is atomic; a start pulse landing in it is dropped.
  assign restart    = i_start && (state != WRITE);

  assign is_hlt     = (o_mem_data[INST_W-1:INST_W-5] == 5'b00000);
  assign addr_full  = &addr;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (i_start) state_next = LOAD_HI;
      end
      LOAD_HI: begin
        if (i_start)         state_next = LOAD_HI;
        else if (byte_avail) state_next = LOAD_LO;
      end
      LOAD_LO: begin
        if (i_start)         state_next = LOAD_HI;
        else if (byte_avail) state_next = WRITE;
      end
      WRITE: begin
        if (is_hlt) begin
`ifdef PROG_LOADER_CKSUM_EN
          state_next = CKSUM;
`else
          state_next = DONE;
`endif
        end else if (addr_full) begin
          state_next = ERR;
        end else begin
          state_next = LOAD_HI;
        end
      end
`ifdef PROG_LOADER_CKSUM_EN
      CKSUM: begin
        if (i_start)         state_next = LOAD_HI;
        else if (byte_avail) state_next = (byte_val == cksum) ? DONE : ERR;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Datapath: address/count, word assembly, holding register, checksum.
  // o_mem_addr/o_mem_data are loaded when the low byte arrives so they are
  // valid throughout the write cycle and keep their value afterwards.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr       <= '0;
      count      <= '0;
      hi_byte    <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
`ifdef PROG_LOADER_CKSUM_EN
      cksum      <= '0;
`endif
    end else if (restart) begin
      addr       <= '0;
      count      <= '0;
      hi_byte    <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
`ifdef PROG_LOADER_CKSUM_EN
      cksum      <= '0;
`endif
    end else begin
      case (state)
        LOAD_HI, LOAD_LO: begin
          if (byte_avail) begin
            if (state == LOAD_HI) begin
              hi_byte <= byte_val;
            end else begin
              o_mem_addr <= addr;
              o_mem_data <= {hi_byte, byte_val};
            end
`ifdef PROG_LOADER_CKSUM_EN
            cksum <= cksum ^ byte_val;
`endif
            // Held byte consumed; a simultaneous live byte takes its place.
            hold_valid <= hold_valid & i_rx_valid;
            if (hold_valid && i_rx_valid) hold_data <= i_rx_data;
          end
        end
        WRITE: begin
          addr  <= addr + ADDR_W'(1);
          count <= count + (ADDR_W+1)'(1);
          if (i_rx_valid) begin
            hold_valid <= 1'b1;
            hold_data  <= i_rx_data;
          end
        end
`ifdef PROG_LOADER_CKSUM_EN
        CKSUM: begin
          if (byte_avail) begin
            hold_valid <= hold_valid & i_rx_valid;
            if (hold_valid && i_rx_valid) hold_data <= i_rx_data;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign o_mem_we = (state == WRITE);
  assign o_count  = count;
  assign o_done   = (state == DONE);
  assign o_cpu_en = o_done;
  assign o_err    = (state == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader -- directed self-checking bench for prog_loader.
//
// Two instances share all inputs: a default-width loader (ADDR_W=11) and a
// tiny one (ADDR_W=2) used to exercise the memory-full path. Memory writes of
// each instance are recorded on the falling edge into queues. Build with
// PROG_LOADER_CKSUM_EN defined to also cover the checksum feature.

module tb_prog_loader;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_rx_valid = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;

  logic        o_mem_we;
  logic [10:0] o_mem_addr;
  logic [15:0] o_mem_data;
  logic [11:0] o_count;
  logic        o_done, o_cpu_en, o_err;

  logic        s_mem_we;
  logic [1:0]  s_mem_addr;
  logic [15:0] s_mem_data;
  logic [2:0]  s_count;
  logic        s_done, s_cpu_en, s_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [15:0] wq_addr[$];
  logic [15:0] wq_data[$];
  logic [15:0] sq_addr[$];
  logic [15:0] sq_data[$];

  prog_loader #(.ADDR_W(11)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .o_count(o_count), .o_done(o_done), .o_cpu_en(o_cpu_en), .o_err(o_err)
  );

  prog_loader #(.ADDR_W(2)) dut_s (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .o_mem_we(s_mem_we), .o_mem_addr(s_mem_addr), .o_mem_data(s_mem_data),
    .o_count(s_count), .o_done(s_done), .o_cpu_en(s_cpu_en), .o_err(s_err)
  );

  always #5 i_clk = ~i_clk;

  // Record every memory write of both instances
  always @(negedge i_clk) begin
    if (o_mem_we === 1'b1) begin
      wq_addr.push_back({5'd0, o_mem_addr});
      wq_data.push_back(o_mem_data);
    end
    if (s_mem_we === 1'b1) begin
      sq_addr.push_back({14'd0, s_mem_addr});
      sq_data.push_back(s_mem_data);
    end
  end

  task automatic clear_queues();
    wq_addr.delete(); wq_data.delete();
    sq_addr.delete(); sq_data.delete();
  endtask

  // Called at a falling edge; pulses i_start for one cycle
  task automatic do_start();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  // Called at a falling edge; one-cycle byte strobe then 'idle' empty cycles
  task automatic rx_byte(input logic [7:0] b, input int idle);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
    repeat (idle) @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    total_cnt++; if (o_mem_we !== 1'b0) $display("[TB] FAIL reset_we got %0b want 0", o_mem_we); else pass_cnt++;
    total_cnt++; if (o_mem_addr !== 11'd0) $display("[TB] FAIL reset_addr got %0h want 0", o_mem_addr); else pass_cnt++;
    total_cnt++; if (o_mem_data !== 16'd0) $display("[TB] FAIL reset_data got %0h want 0", o_mem_data); else pass_cnt++;
    total_cnt++; if (o_count !== 12'd0) $display("[TB] FAIL reset_count got %0d want 0", o_count); else pass_cnt++;
    total_cnt++; if (o_done !== 1'b0) $display("[TB] FAIL reset_done got %0b want 0", o_done); else pass_cnt++;
    total_cnt++; if (o_cpu_en !== 1'b0) $display("[TB] FAIL reset_cpu_en got %0b want 0", o_cpu_en); else pass_cnt++;
    total_cnt++; if (o_err !== 1'b0) $display("[TB] FAIL reset_err got %0b want 0", o_err); else pass_cnt++;
    i_rst = 1'b0;
    @(negedge i_clk);
    // Bytes without a start pulse must not produce writes
    clear_queues();
    rx_byte(8'h18, 1);
    rx_byte(8'h05, 1);
    total_cnt++; if (wq_addr.size() !== 0) $display("[TB] FAIL idle_ignore writes got %0d want 0", wq_addr.size()); else pass_cnt++;
  endtask

  task automatic test_basic();
    clear_queues();
    do_start();
    rx_byte(8'h18, 1); rx_byte(8'h05, 1);
    rx_byte(8'h20, 1); rx_byte(8'h07, 1);
    rx_byte(8'h00, 1); rx_byte(8'h00, 2);
`ifdef PROG_LOADER_CKSUM_EN
    total_cnt++; if (o_done !== 1'b0) $display("[TB] FAIL basic_wait_cksum done got %0b want 0", o_done); else pass_cnt++;
    rx_byte(8'h3A, 2);
`endif
    repeat (2) @(negedge i_clk);
    total_cnt++; if (wq_addr.size() !== 3) $display("[TB] FAIL basic_nwrites got %0d want 3", wq_addr.size()); else pass_cnt++;
    total_cnt++; if (wq_addr[0] !== 16'd0 || wq_data[0] !== 16'h1805) $display("[TB] FAIL basic_w0 got %0h@%0h want 1805@0", wq_data[0], wq_addr[0]); else pass_cnt++;
    total_cnt++; if (wq_addr[1] !== 16'd1 || wq_data[1] !== 16'h2007) $display("[TB] FAIL basic_w1 got %0h@%0h want 2007@1", wq_data[1], wq_addr[1]); else pass_cnt++;
    total_cnt++; if (wq_addr[2] !== 16'd2 || wq_data[2] !== 16'h0000) $display("[TB] FAIL basic_w2 got %0h@%0h want 0000@2", wq_data[2], wq_addr[2]); else pass_cnt++;
    total_cnt++; if (o_count !== 12'd3) $display("[TB] FAIL basic_count got %0d want 3", o_count); else pass_cnt++;
    total_cnt++; if (o_done !== 1'b1) $display("[TB] FAIL basic_done got %0b want 1", o_done); else pass_cnt++;
    total_cnt++; if (o_cpu_en !== 1'b1) $display("[TB] FAIL basic_cpu_en got %0b want 1", o_cpu_en); else pass_cnt++;
    total_cnt++; if (o_err !== 1'b0) $display("[TB] FAIL basic_err got %0b want 0", o_err); else pass_cnt++;
    total_cnt++; if (o_mem_we !== 1'b0) $display("[TB] FAIL basic_we_idle got %0b want 0", o_mem_we); else pass_cnt++;
    total_cnt++; if (o_mem_data !== 16'h0000 || o_mem_addr !== 11'd2) $display("[TB] FAIL basic_hold_out got %0h@%0h want 0000@2", o_mem_data, o_mem_addr); else pass_cnt++;
  endtask

  task automatic test_holding();
    clear_queues();
    do_start();
    rx_byte(8'h12, 0);
    rx_byte(8'h34, 0);
    // One cycle after the low byte the write must be in progress
    total_cnt++; if (o_mem_we !== 1'b1) $display("[TB] FAIL hold_latency we got %0b want 1", o_mem_we); else pass_cnt++;
    total_cnt++; if (o_mem_data !== 16'h1234) $display("[TB] FAIL hold_latency data got %0h want 1234", o_mem_data); else pass_cnt++;
    total_cnt++; if (o_mem_addr !== 11'd0) $display("[TB] FAIL hold_latency addr got %0h want 0", o_mem_addr); else pass_cnt++;
    // This byte arrives during the write cycle and must be held
    rx_byte(8'h56, 2);
    rx_byte(8'h78, 1);
    rx_byte(8'h00, 0);
`ifdef PROG_LOADER_CKSUM_EN
    rx_byte(8'h05, 0);
    rx_byte(8'h0D, 2);
`else
    rx_byte(8'h05, 2);
`endif
    repeat (2) @(negedge i_clk);
    total_cnt++; if (wq_addr.size() !== 3) $display("[TB] FAIL hold_nwrites got %0d want 3", wq_addr.size()); else pass_cnt++;
    total_cnt++; if (wq_addr[0] !== 16'd0 || wq_data[0] !== 16'h1234) $display("[TB] FAIL hold_w0 got %0h@%0h want 1234@0", wq_data[0], wq_addr[0]); else pass_cnt++;
    total_cnt++; if (wq_addr[1] !== 16'd1 || wq_data[1] !== 16'h5678) $display("[TB] FAIL hold_w1 got %0h@%0h want 5678@1", wq_data[1], wq_addr[1]); else pass_cnt++;
    total_cnt++; if (wq_addr[2] !== 16'd2 || wq_data[2] !== 16'h0005) $display("[TB] FAIL hold_w2 got %0h@%0h want 0005@2", wq_data[2], wq_addr[2]); else pass_cnt++;
    total_cnt++; if (o_count !== 12'd3) $display("[TB] FAIL hold_count got %0d want 3", o_count); else pass_cnt++;
    total_cnt++; if (o_done !== 1'b1) $display("[TB] FAIL hold_done got %0b want 1", o_done); else pass_cnt++;
  endtask

  task automatic test_mem_full();
    logic [7:0] hi;
    clear_queues();
    do_start();
    for (int i = 0; i < 5; i++) begin
      hi = 8'h10 + 8'(i);
      rx_byte(hi, 1);
      rx_byte(8'(i), 1);
    end
    repeat (3) @(negedge i_clk);
    total_cnt++; if (sq_addr.size() !== 4) $display("[TB] FAIL full_nwrites got %0d want 4", sq_addr.size()); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (sq_addr[i] !== 16'(i) || sq_data[i] !== {8'h10 + 8'(i), 8'(i)})
        $display("[TB] FAIL full_w%0d got %0h@%0h want %0h@%0h", i, sq_data[i], sq_addr[i], {8'h10 + 8'(i), 8'(i)}, i);
      else pass_cnt++;
    end
    total_cnt++; if (s_err !== 1'b1) $display("[TB] FAIL full_err got %0b want 1", s_err); else pass_cnt++;
    total_cnt++; if (s_done !== 1'b0 || s_cpu_en !== 1'b0) $display("[TB] FAIL full_done got %0b/%0b want 0/0", s_done, s_cpu_en); else pass_cnt++;
    total_cnt++; if (s_count !== 3'd4) $display("[TB] FAIL full_count got %0d want 4", s_count); else pass_cnt++;
    total_cnt++; if (o_count !== 12'd5 || o_err !== 1'b0) $display("[TB] FAIL wide_count got %0d err %0b want 5 err 0", o_count, o_err); else pass_cnt++;
  endtask

  task automatic test_cksum();
    clear_queues();
    do_start();
    rx_byte(8'h08, 1); rx_byte(8'h01, 1);
    rx_byte(8'h00, 1); rx_byte(8'h00, 2);
`ifdef PROG_LOADER_CKSUM_EN
    rx_byte(8'h09, 2);
`endif
    total_cnt++; if (o_done !== 1'b1 || o_err !== 1'b0) $display("[TB] FAIL cksum_good got done %0b err %0b want 1 0", o_done, o_err); else pass_cnt++;
    total_cnt++; if (o_count !== 12'd2) $display("[TB] FAIL cksum_count got %0d want 2", o_count); else pass_cnt++;
    total_cnt++; if (wq_data.size() !== 2 || wq_data[0] !== 16'h0801 || wq_data[1] !== 16'h0000) $display("[TB] FAIL cksum_writes got n=%0d %0h %0h want 2 0801 0000", wq_data.size(), wq_data[0], wq_data[1]); else pass_cnt++;
`ifdef PROG_LOADER_CKSUM_EN
    do_start();
    total_cnt++; if (o_done !== 1'b0 || o_cpu_en !== 1'b0) $display("[TB] FAIL cksum_restart_clear got %0b/%0b want 0/0", o_done, o_cpu_en); else pass_cnt++;
    rx_byte(8'h08, 1); rx_byte(8'h01, 1);
    rx_byte(8'h00, 1); rx_byte(8'h00, 2);
    rx_byte(8'h08, 2);
    total_cnt++; if (o_err !== 1'b1 || o_done !== 1'b0) $display("[TB] FAIL cksum_bad got err %0b done %0b want 1 0", o_err, o_done); else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid();
    clear_queues();
    do_start();
    rx_byte(8'h18, 1); rx_byte(8'h05, 1);
    rx_byte(8'h20, 1);
    total_cnt++; if (o_count !== 12'd1) $display("[TB] FAIL mid_pre_count got %0d want 1", o_count); else pass_cnt++;
    #2 i_rst = 1'b1;
    #1;
    total_cnt++; if (o_count !== 12'd0) $display("[TB] FAIL mid_async_count got %0d want 0", o_count); else pass_cnt++;
    total_cnt++; if (o_mem_data !== 16'd0 || o_mem_addr !== 11'd0) $display("[TB] FAIL mid_async_mem got %0h@%0h want 0@0", o_mem_data, o_mem_addr); else pass_cnt++;
    total_cnt++; if (o_mem_we !== 1'b0 || o_done !== 1'b0 || o_err !== 1'b0) $display("[TB] FAIL mid_async_flags got we %0b done %0b err %0b want 0", o_mem_we, o_done, o_err); else pass_cnt++;
    @(negedge i_clk);
    rx_byte(8'h07, 2);
    total_cnt++; if (wq_addr.size() !== 1) $display("[TB] FAIL mid_no_write got %0d want 1", wq_addr.size()); else pass_cnt++;
    i_rst = 1'b0;
    @(negedge i_clk);
    clear_queues();
    do_start();
    rx_byte(8'h30, 1); rx_byte(8'h01, 1);
    rx_byte(8'h00, 1); rx_byte(8'h00, 2);
`ifdef PROG_LOADER_CKSUM_EN
    rx_byte(8'h31, 2);
`endif
    total_cnt++; if (wq_addr.size() !== 2 || wq_addr[0] !== 16'd0 || wq_data[0] !== 16'h3001) $display("[TB] FAIL mid_reload got n=%0d %0h@%0h want 2 3001@0", wq_addr.size(), wq_data[0], wq_addr[0]); else pass_cnt++;
    total_cnt++; if (o_done !== 1'b1 || o_count !== 12'd2) $display("[TB] FAIL mid_reload_done got %0b cnt %0d want 1 2", o_done, o_count); else pass_cnt++;
  endtask

  initial begin
    @(negedge i_clk);
    test_reset();
    test_basic();
    test_holding();
    test_mem_full();
    test_cksum();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
